event_unpacker: RTL and testbench
=================================

# event_unpacker

Receive-side counterpart of the event filter. Accepts 8-bit packed event words `{x[1:0], y[1:0], p[1:0], t[1:0]}` and discards null (filtered-out) words. Extends the 2-bit wrapping timestamp to TS_W bits and buffers decoded events in a small FIFO with valid/ready handshakes on both sides. Sits between the packed-event link and downstream event consumers (accumulators, readout).

## Interface
- TS_W, 8, width of reconstructed timestamp; minimum 3.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_word  in  8  packed event word; x=[7:6], y=[5:4], p=[3:2], t=[1:0].
- in_valid  in  1  in_word valid.
- in_ready  out  1  block can accept in_word.
- out_x  out  2  decoded x.
- out_y  out  2  decoded y.
- out_p  out  2  decoded polarity.
- out_t  out  TS_W  extended timestamp.
- out_valid  out  1  out_* hold a valid event.
- out_ready  in  1  consumer accepts event.
- null_cnt  out  8  saturating count of null words consumed.

## Operation
- Accept occurs when in_valid && in_ready. Emit occurs when out_valid && out_ready.
- in_ready = !full. There is no combinational path from out_ready to in_ready.
- Null word: in_word == 8'h00. It is accepted and consumed, and it is never written to the FIFO. null_cnt increments and saturates at 8'hFF. Timestamp state is not updated.
- Timestamp unwrap state:
  - last_t: 2 bits, reset 0.
  - epoch: TS_W-2 bits, reset 0.
- Unwrap on each accepted non-null word with raw t:
  - if t < last_t, then epoch_n = epoch + 1 (modulo 2^(TS_W-2)); otherwise epoch_n = epoch.
  - t == last_t does not increment epoch.
  - The stored event gets out_t = {epoch_n, t}.
  - Registers update: last_t <= t, epoch <= epoch_n.
- FIFO:
  - Entry = {x, y, p, out_t}; entries are stored in registers.
  - Write pointer, read pointer and occupancy counter are each log2(DEPTH)+1 bits.
  - full when count == DEPTH; empty when count == 0.
  - Simultaneous push and pop: count is unchanged, and both pointers advance, wrapping modulo DEPTH.
  - A non-null accept while empty and no pop: the event becomes visible the next cycle.
- Outputs:
  - out_valid = !empty.
  - out_x/y/p/t present the head entry.
  - While out_valid && !out_ready, out_* hold stable.
  - While empty, out_* are don't-care, but the bench expects 0 after reset.
- Reset (rst_n low at a clock edge), including mid-operation:
  - FIFO is flushed and all pending events are lost.
  - count=0, pointers=0, last_t=0, epoch=0, null_cnt=0.
  - Outputs the cycle after reset: out_valid=0, in_ready=1, out_x/y/p/t=0.
  - While rst_n is low, in_ready=0 and no word is accepted.

## Timing
- Accept-to-out_valid latency: 1 cycle.
- Throughput: 1 word per cycle in and 1 event per cycle out when the FIFO is neither full nor empty.
- Full: in_ready drops in the cycle after the DEPTH-th stored event is written. A pop in that cycle re-asserts in_ready on the next cycle, not the same cycle.
- A null word is accepted even when the FIFO is full? No: in_ready=0 applies to all words when full. A null word therefore waits for space.
- null_cnt updates 1 cycle after the accept.

## Configuration
- EVT_POLFILT_EN defined: a word is also null when p != 2'b01. It is consumed, counted in null_cnt, and leaves the timestamp state untouched.
- EVT_POLFILT_EN undefined: only 8'h00 is null. All other words, including p=2'b00/2'b10/2'b11, are decoded and stored.

## Test plan
- Reset then single word 8'b01_10_01_11 with out_ready=1 -> next cycle out_valid=1, x=1, y=2, p=1, out_t=8'h03. The following cycle out_valid=0.
- Words with t sequence 1,2,3,0,0,1 (p=01, TS_W=8) -> out_t = 01,02,03,04,04,05. Repeat until epoch wraps: 64 wraps return out_t to 8'h00.
- out_ready=0, push 5 non-null words with DEPTH=4 -> 4 accepted, in_ready=0 from the cycle after the 4th. The 5th is held. Then out_ready=1 -> events emitted in order, 5th accepted, no loss or duplication.
- Interleave 8'h00 words among 3 events -> only 3 emitted, null_cnt = number of 8'h00. The timestamp of the event after a null is unaffected. 300 nulls -> null_cnt=8'hFF.
- 3 events buffered, assert rst_n=0 for one cycle -> out_valid=0, null_cnt=0. The next word with t=2 yields out_t=8'h02.
- With EVT_POLFILT_EN, word 8'b11_11_10_01 -> not emitted, null_cnt=1. Without the macro, the same word -> emitted with p=2.

Source files
------------

// File: rtl/event_unpacker.sv
// Packed-event receiver: drops null words, unwraps the 2-bit timestamp to TS_W bits
// and buffers decoded events in a DEPTH-entry FIFO. Optional macro: EVT_POLFILT_EN.
module event_unpacker #(
  parameter int TS_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      in_word,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [1:0]      out_x,
  output logic [1:0]      out_y,
  output logic [1:0]      out_p,
  output logic [TS_W-1:0] out_t,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      null_cnt
);
  // Handshake: a word moves on in_valid && in_ready; an event moves on
  // out_valid && out_ready. in_ready depends only on registered occupancy.
  localparam int AW  = $clog2(DEPTH);
  localparam int EPW = TS_W - 2;
  localparam int EW  = 6 + TS_W;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [EW-1:0]  mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr, count;
  logic [1:0]     last_t;
  logic [EPW-1:0] epoch, epoch_n;
  logic           full, empty, is_null, accept, push, pop;
  logic [EW-1:0]  head;
  logic           unused_ptr_msbs;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = rst_n && !full;

`ifdef EVT_POLFILT_EN
  assign is_null = (in_word == 8'h00) || (in_word[3:2] != 2'b01);
`else
  assign is_null = (in_word == 8'h00);
`endif

  assign accept  = in_valid && in_ready;
  assign push    = accept && !is_null;
  assign pop     = !empty && out_ready;
  // A smaller raw timestamp than the last one means the 2-bit counter wrapped.
  assign epoch_n = (in_word[1:0] < last_t) ? epoch + 1'b1 : epoch;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {in_word[7:2], epoch_n, in_word[1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_t   <= '0;
      epoch    <= '0;
      null_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        last_t <= in_word[1:0];
        epoch  <= epoch_n;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (accept && is_null && (null_cnt != 8'hFF)) begin
        null_cnt <= null_cnt + 1'b1;
      end
    end
  end

  // Outputs read zero while empty so the post-reset value is defined.
  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_valid = !empty;
  assign {out_x, out_y, out_p, out_t} = empty ? '0 : head;

  assign unused_ptr_msbs = &{1'b0, wr_ptr[AW], rd_ptr[AW]};
endmodule

// File: tb/tb_event_unpacker.sv
// Bench for event_unpacker: vector table, directed corner sequences and random
// traffic against a queue-based reference model.
module tb_event_unpacker;
  localparam int TS_W  = 8;
  localparam int DEPTH = 4;
  localparam int W     = 6 + TS_W;
`ifdef EVT_POLFILT_EN
  localparam bit POLFILT = 1'b1;
`else
  localparam bit POLFILT = 1'b0;
`endif

  logic            clk, rst_n;
  logic [7:0]      in_word;
  logic            in_valid, in_ready;
  logic [1:0]      out_x, out_y, out_p;
  logic [TS_W-1:0] out_t;
  logic            out_valid, out_ready;
  logic [7:0]      null_cnt;

  event_unpacker #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid),
    .in_ready(in_ready), .out_x(out_x), .out_y(out_y), .out_p(out_p),
    .out_t(out_t), .out_valid(out_valid), .out_ready(out_ready),
    .null_cnt(null_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [W-1:0] exp_q[$];
  int m_last, m_epoch, m_null;
  bit m_acc, m_pop;

  typedef struct {
    logic [7:0]      word;
    bit              emit;
    logic [1:0]      x, y, p;
    logic [TS_W-1:0] t;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_is_null(input logic [7:0] w);
    return (w == 8'h00) || (POLFILT && (w[3:2] != 2'b01));
  endfunction

  task automatic check_model();
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
    chk("null_cnt", 32'(null_cnt), 32'(m_null));
    if (exp_q.size() > 0) chk("head", 32'({out_x, out_y, out_p, out_t}), 32'(exp_q[0]));
  endtask

  task automatic model_edge(input logic [7:0] w, input bit v, input bit r);
    int sz = exp_q.size();
    int t;
    int ext;
    m_acc = v && (sz < DEPTH);
    m_pop = (sz > 0) && r;
    if (m_pop) void'(exp_q.pop_front());
    if (m_acc) begin
      if (model_is_null(w)) begin
        if (m_null < 255) m_null++;
      end else begin
        t = int'(w[1:0]);
        if (t < m_last) m_epoch = (m_epoch + 1) % (1 << (TS_W - 2));
        m_last = t;
        ext = m_epoch * 4 + t;
        exp_q.push_back({w[7:2], ext[TS_W-1:0]});
      end
    end
  endtask

  // driver: one clock cycle with the given inputs
  task automatic cycle(input logic [7:0] w, input bit v, input bit r);
    in_word = w; in_valid = v; out_ready = r;
    #1;
    check_model();
    @(posedge clk);
    model_edge(w, v, r);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0; in_valid = 1'b1; in_word = 8'h67; out_ready = 1'($urandom);
    repeat (cycles) begin
      #1;
      chk("in_ready_in_reset", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    exp_q.delete();
    m_last = 0; m_epoch = 0; m_null = 0;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_null_cnt", 32'(null_cnt), 32'd0);
    chk("rst_outs", 32'({out_x, out_y, out_p, out_t}), 32'd0);
  endtask

  initial begin
    int nulls, emits;
    bit taken;
    logic [7:0] w;
    rst_n = 1'b0; in_word = '0; in_valid = 1'b0; out_ready = 1'b0;

    // first word after reset, 1-cycle latency then drained
    do_reset(2);
    cycle(8'h67, 1'b1, 1'b1);
    chk("a_valid", 32'(out_valid), 32'd1);
    chk("a_x", 32'(out_x), 32'd1);
    chk("a_y", 32'(out_y), 32'd2);
    chk("a_p", 32'(out_p), 32'd1);
    chk("a_t", 32'(out_t), 32'h03);
    cycle(8'h00, 1'b0, 1'b1);
    chk("a_drained", 32'(out_valid), 32'd0);

    // vector table from a fresh reset, out_ready held high
    tbl[0] = '{8'h15, 1'b1, 2'd0, 2'd1, 2'd1, 8'h01};
    tbl[1] = '{8'hB6, 1'b1, 2'd2, 2'd3, 2'd1, 8'h02};
    tbl[2] = '{8'h00, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00};
    tbl[3] = '{8'hC7, 1'b1, 2'd3, 2'd0, 2'd1, 8'h03};
    tbl[4] = '{8'h54, 1'b1, 2'd1, 2'd1, 2'd1, 8'h04};
    tbl[5] = '{8'h24, 1'b1, 2'd0, 2'd2, 2'd1, 8'h04};
    tbl[6] = '{8'h00, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00};
    tbl[7] = '{8'h85, 1'b1, 2'd2, 2'd0, 2'd1, 8'h05};
`ifdef EVT_POLFILT_EN
    tbl[8] = '{8'hF9, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00};
    tbl[9] = '{8'h42, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00};
`else
    tbl[8] = '{8'hF9, 1'b1, 2'd3, 2'd3, 2'd2, 8'h05};
    tbl[9] = '{8'h42, 1'b1, 2'd1, 2'd0, 2'd0, 8'h06};
`endif
    do_reset(1);
    nulls = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].word, 1'b1, 1'b1);
      if (!tbl[i].emit) nulls++;
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].emit));
      if (tbl[i].emit) begin
        chk($sformatf("tbl%0d_evt", i), 32'({out_x, out_y, out_p, out_t}),
            32'({tbl[i].x, tbl[i].y, tbl[i].p, tbl[i].t}));
      end
    end
    chk("tbl_null_cnt", 32'(null_cnt), 32'(nulls));

    // epoch wrap: 64 groups of t=1,2,3,0
    do_reset(1);
    for (int g = 0; g < 64; g++) begin
      for (int k = 1; k <= 4; k++) begin
        w = {6'b000001, 2'(k % 4)};
        cycle(w, 1'b1, 1'b1);
        if (g == 0 && k == 4) chk("wrap_first", 32'(out_t), 32'h04);
      end
    end
    chk("wrap_valid", 32'(out_valid), 32'd1);
    chk("wrap_t", 32'(out_t), 32'h00);

    // full: 5 words with out_ready low, then drain
    do_reset(1);
    for (int i = 0; i < 5; i++) cycle(8'h45 + 8'(i), 1'b1, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head", 32'({out_x, out_y, out_p, out_t}), 32'({6'b010001, 8'h01}));
    taken = 1'b0; emits = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(8'h49, !taken, 1'b1);
      if (m_acc) taken = 1'b1;
      if (m_pop) emits++;
    end
    chk("full_fifth_taken", 32'(taken), 32'd1);
    chk("full_emits", 32'(emits), 32'd5);

    // nulls interleaved with 3 events, then saturation
    do_reset(1);
    emits = 0;
    foreach (tbl[i]) begin end
    for (int i = 0; i < 9; i++) begin
      w = (i == 1) ? 8'h15 : (i == 4) ? 8'hB6 : (i == 6) ? 8'hC7 : 8'h00;
      cycle(w, i < 7, 1'b1);
      if (m_pop) emits++;
    end
    chk("int_emits", 32'(emits), 32'd3);
    chk("int_null_cnt", 32'(null_cnt), 32'd4);
    for (int i = 0; i < 300; i++) cycle(8'h00, 1'b1, 1'b1);
    chk("sat_null_cnt", 32'(null_cnt), 32'hFF);

    // reset with events buffered
    do_reset(1);
    cycle(8'h15, 1'b1, 1'b0);
    cycle(8'hB6, 1'b1, 1'b0);
    cycle(8'hC7, 1'b1, 1'b0);
    cycle(8'h00, 1'b1, 1'b0);
    chk("pre_rst_null", 32'(null_cnt), 32'd1);
    do_reset(1);
    cycle(8'h06, 1'b1, 1'b1);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_t", 32'(out_t), 32'h02);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1);
      end else begin
        w = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
        cycle(w, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
